// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage and architectural register file for the dual-issue core.
// Each lane picks its result from the AU, multiplier or shared LSU source,
// then up to two results commit per cycle into a 32x32 register file whose
// x0 always reads as zero. Four combinational read ports serve decode/issue,
// with write-through bypass from the lanes currently in writeback. A counter
// tracks how many register writes have committed since reset.
//
// Ports:
//   clk, rst_n                         core clock, async active-low reset
//   reg_write1_wb / reg_write2_wb      per-lane write request
//   rd1_wb / rd2_wb                    per-lane destination register
//   au_mul_lsu1_wb / au_mul_lsu2_wb    per-lane one-hot source select
//   au1_wb, au2_wb, mul1_wb, mul2_wb   per-lane AU / multiplier results
//   lsu_wb                             shared LSU load result
//   rs1_a, rs2_a, rs1_b, rs2_b         read addresses (lane A / lane B)
//   rdata1_a, rdata2_a, rdata1_b, rdata2_b  bypassed read data
//   wb_en1 / wb_en2                    effective commit enable per lane
//   wb_data1 / wb_data2                selected writeback value per lane
//   commit_count                       committed writes since reset (wraps)

module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reg_write1_wb,
   input  logic             reg_write2_wb,
   input  logic [4:0]       rd1_wb,
   input  logic [4:0]       rd2_wb,
   input  logic [2:0]       au_mul_lsu1_wb,
   input  logic [2:0]       au_mul_lsu2_wb,
   input  logic [XLEN-1:0]  au1_wb,
   input  logic [XLEN-1:0]  au2_wb,
   input  logic [XLEN-1:0]  mul1_wb,
   input  logic [XLEN-1:0]  mul2_wb,
   input  logic [XLEN-1:0]  lsu_wb,
   input  logic [4:0]       rs1_a,
   input  logic [4:0]       rs2_a,
   input  logic [4:0]       rs1_b,
   input  logic [4:0]       rs2_b,
   output logic [XLEN-1:0]  rdata1_a,
   output logic [XLEN-1:0]  rdata2_a,
   output logic [XLEN-1:0]  rdata1_b,
   output logic [XLEN-1:0]  rdata2_b,
   output logic             wb_en1,
   output logic             wb_en2,
   output logic [XLEN-1:0]  wb_data1,
   output logic [XLEN-1:0]  wb_data2,
   output logic [CNT_W-1:0] commit_count
);

   // x0 has no storage at all; only x1..x31 exist.
   logic [XLEN-1:0]  regs [1:31];
   logic             legal1;
   logic             legal2;
   logic             lane1_drop;
   logic [CNT_W-1:0] count_q;

   // Lane 1 source mux. Only a clean one-hot code is a legal selection;
   // anything else (none or several bits set) yields zero and blocks the
   // commit so a malformed control word can never corrupt the register file.
   always_comb begin
      wb_data1 = '0;
      legal1   = 1'b0;
      case (au_mul_lsu1_wb)
         3'b001: begin wb_data1 = au1_wb;  legal1 = 1'b1; end
         3'b010: begin wb_data1 = mul1_wb; legal1 = 1'b1; end
         3'b100: begin wb_data1 = lsu_wb;  legal1 = 1'b1; end
         default: begin wb_data1 = '0;     legal1 = 1'b0; end
      endcase
   end

   // Lane 2 source mux, identical rules to lane 1. The LSU result is shared,
   // so either lane may pick it up.
   always_comb begin
      wb_data2 = '0;
      legal2   = 1'b0;
      case (au_mul_lsu2_wb)
         3'b001: begin wb_data2 = au2_wb;  legal2 = 1'b1; end
         3'b010: begin wb_data2 = mul2_wb; legal2 = 1'b1; end
         3'b100: begin wb_data2 = lsu_wb;  legal2 = 1'b1; end
         default: begin wb_data2 = '0;     legal2 = 1'b0; end
      endcase
   end

   // A lane commits only when it asks to, targets a real register and has a
   // legal source. Writes to x0 are swallowed here so they neither reach the
   // array nor bump the commit counter.
   assign wb_en1 = reg_write1_wb && (rd1_wb != 5'd0) && legal1;
   assign wb_en2 = reg_write2_wb && (rd2_wb != 5'd0) && legal2;

   // When both lanes hit the same register, lane 2 is the younger
   // instruction and wins; lane 1's array write is suppressed but it still
   // counts as a committed write.
   assign lane1_drop = wb_en2 && (rd1_wb == rd2_wb);

   // Register array update. Reset clears every architectural register, and
   // being asynchronous it also discards any commit pending for that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wb_en1 && !lane1_drop) begin
            regs[rd1_wb] <= wb_data1;
         end
         if (wb_en2) begin
            regs[rd2_wb] <= wb_data2;
         end
      end
   end

   // Commit counter: adds 0, 1 or 2 per cycle and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(wb_en1) + CNT_W'(wb_en2);
      end
   end

   assign commit_count = count_q;

   // One read port: x0 is always zero, then lane 2 bypass (younger, so it
   // shadows lane 1 on a same-rd collision), then lane 1 bypass, then the
   // array. This keeps reads consistent with what the array will hold after
   // the current edge.
   function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
      logic [XLEN-1:0] value;
      value = '0;
      if (addr == 5'd0) begin
         value = '0;
      end else if (wb_en2 && (rd2_wb == addr)) begin
         value = wb_data2;
      end else if (wb_en1 && (rd1_wb == addr)) begin
         value = wb_data1;
      end else begin
         value = regs[addr];
      end
      return value;
   endfunction

   assign rdata1_a = read_port(rs1_a);
   assign rdata2_a = read_port(rs2_a);
   assign rdata1_b = read_port(rs1_b);
   assign rdata2_b = read_port(rs2_b);

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Self-checking bench for wb_regfile. Each stimulus step pushes the values the
// design should show onto a scoreboard queue; just before the next rising
// edge the queue is drained against the live outputs. A second instance with
// a 2-bit counter shares all inputs so counter wrap-around is reachable in a
// handful of cycles.

module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_write1_wb, reg_write2_wb;
   logic [4:0]  rd1_wb, rd2_wb;
   logic [2:0]  au_mul_lsu1_wb, au_mul_lsu2_wb;
   logic [31:0] au1_wb, au2_wb, mul1_wb, mul2_wb, lsu_wb;
   logic [4:0]  rs1_a, rs2_a, rs1_b, rs2_b;
   logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
   logic        wb_en1, wb_en2;
   logic [31:0] wb_data1, wb_data2;
   logic [31:0] commit_count;

   logic [31:0] s_rdata1_a, s_rdata2_a, s_rdata1_b, s_rdata2_b;
   logic        s_wb_en1, s_wb_en2;
   logic [31:0] s_wb_data1, s_wb_data2;
   logic [1:0]  s_commit_count;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_write1_wb(reg_write1_wb), .reg_write2_wb(reg_write2_wb),
      .rd1_wb(rd1_wb), .rd2_wb(rd2_wb),
      .au_mul_lsu1_wb(au_mul_lsu1_wb), .au_mul_lsu2_wb(au_mul_lsu2_wb),
      .au1_wb(au1_wb), .au2_wb(au2_wb), .mul1_wb(mul1_wb), .mul2_wb(mul2_wb),
      .lsu_wb(lsu_wb),
      .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_b(rs1_b), .rs2_b(rs2_b),
      .rdata1_a(rdata1_a), .rdata2_a(rdata2_a),
      .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
      .wb_en1(wb_en1), .wb_en2(wb_en2),
      .wb_data1(wb_data1), .wb_data2(wb_data2),
      .commit_count(commit_count)
   );

   wb_regfile #(.XLEN(32), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .reg_write1_wb(reg_write1_wb), .reg_write2_wb(reg_write2_wb),
      .rd1_wb(rd1_wb), .rd2_wb(rd2_wb),
      .au_mul_lsu1_wb(au_mul_lsu1_wb), .au_mul_lsu2_wb(au_mul_lsu2_wb),
      .au1_wb(au1_wb), .au2_wb(au2_wb), .mul1_wb(mul1_wb), .mul2_wb(mul2_wb),
      .lsu_wb(lsu_wb),
      .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_b(rs1_b), .rs2_b(rs2_b),
      .rdata1_a(s_rdata1_a), .rdata2_a(s_rdata2_a),
      .rdata1_b(s_rdata1_b), .rdata2_b(s_rdata2_b),
      .wb_en1(s_wb_en1), .wb_en2(s_wb_en2),
      .wb_data1(s_wb_data1), .wb_data2(s_wb_data2),
      .commit_count(s_commit_count)
   );

   // Scoreboard entry: which output to look at and what it must read.
   typedef struct packed {
      logic [3:0]  kind;
      logic [31:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_regs [32];
   logic [31:0] model_cnt;
   string       phase;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Reference behaviour of the source mux and commit enables.
   function automatic logic [31:0] model_data(input logic [2:0] sel, input logic [31:0] au,
                                              input logic [31:0] mul, input logic [31:0] ld);
      case (sel)
         3'b001:  return au;
         3'b010:  return mul;
         3'b100:  return ld;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_legal(input logic [2:0] sel);
      return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
   endfunction

   function automatic logic model_en1();
      return reg_write1_wb && (rd1_wb != 5'd0) && model_legal(au_mul_lsu1_wb);
   endfunction

   function automatic logic model_en2();
      return reg_write2_wb && (rd2_wb != 5'd0) && model_legal(au_mul_lsu2_wb);
   endfunction

   function automatic logic [31:0] model_d1();
      return model_data(au_mul_lsu1_wb, au1_wb, mul1_wb, lsu_wb);
   endfunction

   function automatic logic [31:0] model_d2();
      return model_data(au_mul_lsu2_wb, au2_wb, mul2_wb, lsu_wb);
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] addr);
      if (addr == 5'd0) return 32'h0;
      if (model_en2() && (rd2_wb == addr)) return model_d2();
      if (model_en1() && (rd1_wb == addr)) return model_d1();
      return model_regs[addr];
   endfunction

   function automatic logic [31:0] observe(input logic [3:0] kind);
      case (kind)
         4'd0:    return rdata1_a;
         4'd1:    return rdata2_a;
         4'd2:    return rdata1_b;
         4'd3:    return rdata2_b;
         4'd4:    return {31'h0, wb_en1};
         4'd5:    return {31'h0, wb_en2};
         4'd6:    return wb_data1;
         4'd7:    return wb_data2;
         4'd8:    return commit_count;
         default: return {30'h0, s_commit_count};
      endcase
   endfunction

   function automatic string kind_name(input logic [3:0] kind);
      case (kind)
         4'd0:    return "rdata1_a";
         4'd1:    return "rdata2_a";
         4'd2:    return "rdata1_b";
         4'd3:    return "rdata2_b";
         4'd4:    return "wb_en1";
         4'd5:    return "wb_en2";
         4'd6:    return "wb_data1";
         4'd7:    return "wb_data2";
         4'd8:    return "commit_count";
         default: return "commit_count_2b";
      endcase
   endfunction

   task automatic pushExpect(input logic [3:0] kind, input logic [31:0] value);
      exp_q.push_back('{kind: kind, exp: value});
   endtask

   task automatic modelClear();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_cnt = 32'h0;
   endtask

   // Expectations for every output given the inputs currently driven.
   task automatic pushModel();
      pushExpect(4'd0, model_read(rs1_a));
      pushExpect(4'd1, model_read(rs2_a));
      pushExpect(4'd2, model_read(rs1_b));
      pushExpect(4'd3, model_read(rs2_b));
      pushExpect(4'd4, {31'h0, model_en1()});
      pushExpect(4'd5, {31'h0, model_en2()});
      pushExpect(4'd6, model_d1());
      pushExpect(4'd7, model_d2());
      pushExpect(4'd8, model_cnt);
      pushExpect(4'd9, {30'h0, model_cnt[1:0]});
   endtask

   task automatic driveInputs(input logic we1, input logic [4:0] d1, input logic [2:0] sel1,
                              input logic [31:0] a1, input logic [31:0] m1,
                              input logic we2, input logic [4:0] d2, input logic [2:0] sel2,
                              input logic [31:0] a2, input logic [31:0] m2,
                              input logic [31:0] ld, input logic [4:0] ra1,
                              input logic [4:0] ra2, input logic [4:0] rb1,
                              input logic [4:0] rb2);
      reg_write1_wb = we1; rd1_wb = d1; au_mul_lsu1_wb = sel1; au1_wb = a1; mul1_wb = m1;
      reg_write2_wb = we2; rd2_wb = d2; au_mul_lsu2_wb = sel2; au2_wb = a2; mul2_wb = m2;
      lsu_wb = ld;
      rs1_a = ra1; rs2_a = ra2; rs1_b = rb1; rs2_b = rb2;
   endtask

   task automatic applyStimulus(input logic we1, input logic [4:0] d1, input logic [2:0] sel1,
                                input logic [31:0] a1, input logic [31:0] m1,
                                input logic we2, input logic [4:0] d2, input logic [2:0] sel2,
                                input logic [31:0] a2, input logic [31:0] m2,
                                input logic [31:0] ld, input logic [4:0] ra1,
                                input logic [4:0] ra2, input logic [4:0] rb1,
                                input logic [4:0] rb2);
      driveInputs(we1, d1, sel1, a1, m1, we2, d2, sel2, a2, m2, ld, ra1, ra2, rb1, rb2);
      pushModel();
   endtask

   task automatic readOnly(input logic [4:0] ra1, input logic [4:0] ra2,
                           input logic [4:0] rb1, input logic [4:0] rb2);
      applyStimulus(1'b0, 5'd0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 3'b000, 32'h0, 32'h0,
                    32'h0, ra1, ra2, rb1, rb2);
   endtask

   // Drain the scoreboard on the falling edge, then let the rising edge
   // commit and mirror that commit in the reference model.
   task automatic stepCycle();
      exp_t e;
      logic en1, en2;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput({phase, "/", kind_name(e.kind)}, observe(e.kind), e.exp);
      end
      @(posedge clk);
      if (rst_n) begin
         en1 = model_en1();
         en2 = model_en2();
         if (en1 && !(en2 && (rd1_wb == rd2_wb))) model_regs[rd1_wb] = model_d1();
         if (en2) model_regs[rd2_wb] = model_d2();
         model_cnt = model_cnt + {31'h0, en1} + {31'h0, en2};
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      modelClear();
      $display("[TB] starting wb_regfile bench");

      // In reset: bypass still visible, nothing commits.
      phase = "in_reset";
      applyStimulus(1'b1, 5'd3, 3'b001, 32'h0000ABCD, 32'h0, 1'b0, 5'd0, 3'b000, 32'h0, 32'h0,
                    32'h0, 5'd3, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd0, 32'h0000ABCD);
      stepCycle();
      readOnly(5'd3, 5'd3, 5'd3, 5'd3);
      rst_n = 1'b1;
      pushExpect(4'd0, 32'h0);
      stepCycle();

      // Every address on every port reads zero after reset.
      phase = "post_reset";
      for (int a = 0; a < 32; a++) begin
         readOnly(5'(a), 5'(a), 5'(a), 5'(a));
         stepCycle();
      end

      // Dual commit to different registers with same-cycle bypass.
      phase = "dual";
      applyStimulus(1'b1, 5'd5, 3'b001, 32'hDEADBEEF, 32'h0, 1'b1, 5'd6, 3'b010, 32'h0,
                    32'h12345678, 32'h0, 5'd5, 5'd6, 5'd0, 5'd0);
      pushExpect(4'd0, 32'hDEADBEEF);
      stepCycle();
      readOnly(5'd5, 5'd0, 5'd0, 5'd6);
      pushExpect(4'd0, 32'hDEADBEEF);
      pushExpect(4'd3, 32'h12345678);
      pushExpect(4'd8, 32'd2);
      stepCycle();

      // Same-rd collision: lane 2 (LSU) wins, both count.
      phase = "collide";
      applyStimulus(1'b1, 5'd7, 3'b001, 32'h11, 32'h0, 1'b1, 5'd7, 3'b100, 32'h0, 32'h0,
                    32'h22, 5'd7, 5'd5, 5'd6, 5'd7);
      pushExpect(4'd0, 32'h22);
      stepCycle();
      readOnly(5'd7, 5'd7, 5'd7, 5'd7);
      pushExpect(4'd0, 32'h22);
      pushExpect(4'd8, 32'd4);
      stepCycle();

      // Write to x0 is swallowed.
      phase = "x0";
      applyStimulus(1'b1, 5'd0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 3'b000, 32'h0, 32'h0,
                    32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd4, 32'h0);
      pushExpect(4'd0, 32'h0);
      stepCycle();
      readOnly(5'd0, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd8, 32'd4);
      stepCycle();

      // Multi-hot select blocks the commit and zeroes the data.
      phase = "illegal";
      applyStimulus(1'b0, 5'd0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd9, 3'b011, 32'hAAAA,
                    32'hBBBB, 32'hCCCC, 5'd9, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd5, 32'h0);
      pushExpect(4'd7, 32'h0);
      stepCycle();
      readOnly(5'd9, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd0, 32'h0);
      stepCycle();

      // Every select code on lane 1; three of them are legal commits.
      phase = "sel_sweep";
      for (int s = 0; s < 8; s++) begin
         applyStimulus(1'b1, 5'd10, 3'(s), 32'h100 + 32'(s), 32'h200 + 32'(s), 1'b0, 5'd0,
                       3'b000, 32'h0, 32'h0, 32'h300 + 32'(s), 5'd10, 5'd0, 5'd0, 5'd0);
         stepCycle();
         readOnly(5'd10, 5'd0, 5'd0, 5'd0);
         stepCycle();
      end

      // Counter wrap: the 2-bit instance sits at all-ones, a dual commit
      // must land on 1.
      phase = "wrap";
      readOnly(5'd0, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd9, 32'd3);
      pushExpect(4'd8, 32'd7);
      stepCycle();
      applyStimulus(1'b1, 5'd11, 3'b001, 32'h0B, 32'h0, 1'b1, 5'd12, 3'b001, 32'h0C, 32'h0,
                    32'h0, 5'd11, 5'd12, 5'd0, 5'd0);
      stepCycle();
      readOnly(5'd11, 5'd12, 5'd0, 5'd0);
      pushExpect(4'd9, 32'd1);
      pushExpect(4'd8, 32'd9);
      stepCycle();

      // Reset asserted mid-cycle with both lanes enabled: nothing commits.
      phase = "mid_reset";
      driveInputs(1'b1, 5'd13, 3'b001, 32'h55, 32'h0, 1'b1, 5'd14, 3'b010, 32'h0, 32'h66,
                  32'h0, 5'd5, 5'd13, 5'd14, 5'd7);
      #2;
      rst_n = 1'b0;
      modelClear();
      pushModel();
      pushExpect(4'd0, 32'h0);
      pushExpect(4'd1, 32'h55);
      pushExpect(4'd2, 32'h66);
      pushExpect(4'd8, 32'h0);
      stepCycle();
      readOnly(5'd13, 5'd14, 5'd5, 5'd7);
      rst_n = 1'b1;
      pushExpect(4'd0, 32'h0);
      pushExpect(4'd1, 32'h0);
      pushExpect(4'd8, 32'h0);
      stepCycle();

      // First edge after release commits normally.
      phase = "after_reset";
      applyStimulus(1'b1, 5'd15, 3'b001, 32'h77, 32'h0, 1'b0, 5'd0, 3'b000, 32'h0, 32'h0,
                    32'h0, 5'd15, 5'd0, 5'd0, 5'd0);
      stepCycle();
      readOnly(5'd15, 5'd0, 5'd0, 5'd0);
      pushExpect(4'd0, 32'h77);
      pushExpect(4'd8, 32'd1);
      stepCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the dual-issue core. It consumes the registered EX/WB pipeline outputs for both lanes and selects each lane's result from its AU, MUL or LSU source. It commits up to two writes per cycle into a 32x32 register file with x0 hard-wired to zero. It serves four combinational read ports to decode/issue with write-through bypass, and keeps a committed-write counter.

## Interface
- XLEN, 32, data width of registers and results
- CNT_W, 32, width of the committed-write counter
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_write1_wb / reg_write2_wb  in  1  lane 1/2 write request
- rd1_wb / rd2_wb  in  5  lane 1/2 destination register
- au_mul_lsu1_wb / au_mul_lsu2_wb  in  3  lane 1/2 result source select, one-hot
- au1_wb / au2_wb  in  XLEN  lane 1/2 AU result
- mul1_wb / mul2_wb  in  XLEN  lane 1/2 multiplier result
- lsu_wb  in  XLEN  shared LSU load result
- rs1_a, rs2_a, rs1_b, rs2_b  in  5  read addresses for lane A / lane B sources
- rdata1_a, rdata2_a, rdata1_b, rdata2_b  out  XLEN  read data, bypassed
- wb_en1 / wb_en2  out  1  effective commit enable per lane, for forwarding
- wb_data1 / wb_data2  out  XLEN  selected writeback value per lane
- commit_count  out  CNT_W  number of committed register writes since reset

## Operation
- Source select per lane n: 3'b001 selects au_n_wb, 3'b010 selects mul_n_wb, 3'b100 selects lsu_wb.
  - Any other code, including 3'b000 and multi-hot, selects 0 and forces wb_en_n = 0.
- wb_en_n = reg_write_n_wb AND rd_n_wb != 0 AND select code legal. It is combinational.
- wb_data_n is combinational and valid regardless of wb_en_n.
- Commit: on the rising clk edge, regs[rd_n_wb] <= wb_data_n for each lane with wb_en_n = 1.
- Same-rd collision, with wb_en1 = wb_en2 = 1 and rd1_wb == rd2_wb:
  - Lane 2 is program-order younger, so lane 2's value is written.
  - Lane 1's write is dropped.
  - wb_en1 stays 1 for counting.
- Read port: address 0 returns 0.
- Read port, otherwise, in priority order:
  1. wb_data2 if wb_en2 and rd2_wb matches the address.
  2. wb_data1 if wb_en1 and rd1_wb matches the address.
  3. regs[addr].
- commit_count += wb_en1 + wb_en2 each cycle, so the increment is 0, 1 or 2.
  - The counter wraps modulo 2^CNT_W with no saturation.
- x0 has no storage, or any storage it has is never written. All reads of x0 return 0.

## Timing
- Reads are zero-latency combinational, including same-cycle bypass from the writeback inputs.
- A write commits at the edge that ends the cycle in which wb_en is high. It is visible through regs from the next cycle.
- Reset, asynchronous, on rst_n low:
  - All 31 registers clear to 0.
  - commit_count clears to 0.
  - While reset is asserted, rdata* equal the bypass value if an input is enabled, else 0.
  - wb_en*/wb_data* follow their inputs combinationally.
- A reset asserted mid-cycle discards any write pending for that edge. No partial commit.
- First edge after rst_n deasserts performs normal commits.
- No stall or flush input exists. Upstream drives reg_write*_wb = 0 for bubbles.

## Test plan
- After reset, read all 32 addresses on all four ports -> every rdata = 0 and commit_count = 0.
- Lane 1: reg_write=1, rd=5, sel=001, au1=0xDEADBEEF. Lane 2: reg_write=1, rd=6, sel=010, mul2=0x12345678.
  - Same cycle: rs1_a=5 reads 0xDEADBEEF via bypass.
  - Next cycle, inputs idle: rs1_a=5 reads 0xDEADBEEF and rs2_b=6 reads 0x12345678.
  - commit_count = 2.
- Both lanes rd=7, lane 1 au1=0x11, lane 2 sel=100 with lsu=0x22.
  - Same cycle: bypass on rs1_a=7 returns 0x22.
  - Next cycle: x7 reads 0x22 and commit_count increases by 2.
- Lane 1 writes rd=0 with 0xFFFFFFFF -> wb_en1 = 0, x0 reads 0, counter unchanged.
- Lane 2: reg_write=1, rd=9, sel=011 -> wb_en2 = 0, wb_data2 = 0, x9 unchanged.
- Preload commit_count to 0xFFFFFFFF via 2^32-1 commits, or via a forced value in the bench. Then issue one dual commit -> commit_count = 0x00000001.
- Assert rst_n low mid-cycle while both lanes are enabled, then release -> all regs 0 and commit_count 0.
